// File: rtl/msft_dvip_i2c_tx_engine.sv
//-----------------------------------------------------------------------------
// msft_dvip_i2c_tx_engine
//
// I2C master transmit engine. Pulls bytes from a show-ahead TX FIFO and
// shifts them out on an open-drain SCL/SDA pair: START, then for each byte
// 8 data bits MSB first followed by an ACK bit sampled from the target,
// then STOP. Every bit is four SCL quarter-phases of CLK_DIV clk_i cycles.
//
// Parameters
//   CLK_DIV      clk_i cycles per SCL quarter-phase (2..255)
//
// Ports
//   clk_i        system clock, rising edge
//   rstn_i       asynchronous active-low reset
//   go_i         level enable; transfers start/continue while high
//   empty_i      TX FIFO empty flag
//   rdata_i      TX FIFO head byte (show-ahead)
//   rd_o         one-cycle FIFO pop strobe, coincident with byte capture
//   scl_i/sda_i  pad sense
//   scl_oe_o     1 pulls SCL low
//   sda_oe_o     1 pulls SDA low
//   busy_o       high whenever the engine is not idle
//   byte_done_o  one-cycle pulse after each ACKed byte
//   nack_o       one-cycle pulse when a NACK is sampled
//
// Configuration macro
//   I2C_TX_CLK_STRETCH_EN  when defined, the quarter counter holds while the
//                          engine has released SCL but the pad still reads 0
//                          (target clock stretching) in DATA/ACK Q2-Q3 and
//                          STOP Q1. When undefined, scl_i is ignored.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module msft_dvip_i2c_tx_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       go_i,
  input  logic       empty_i,
  input  logic [7:0] rdata_i,
  output logic       rd_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic       nack_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam logic [7:0] QLAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        ack_q, ack_d;

  logic        stretch;
  logic        qtick;

  // SCL drive depends only on state and phase, so the stretch detector can
  // look at it without creating a combinational loop through the FSM.
  always_comb begin
    scl_oe_o = 1'b0;
    case (state_q)
      DATA, ACK: scl_oe_o = ~phase_q[1];
      STOP:      scl_oe_o = (phase_q == 2'd0);
      default:   scl_oe_o = 1'b0;
    endcase
  end

`ifdef I2C_TX_CLK_STRETCH_EN
  // Target holds SCL low after we released it: freeze the quarter timer.
  assign stretch = ~scl_oe_o & ~scl_i &
                   ((((state_q == DATA) || (state_q == ACK)) && phase_q[1]) ||
                    ((state_q == STOP) && (phase_q == 2'd1)));
`else
  assign stretch = scl_i & 1'b0;
`endif

  // Last clk_i of the current quarter (never true while stretched).
  assign qtick  = (qcnt_q == QLAST) && !stretch;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ack_d       = ack_q;
    rd_o        = 1'b0;
    byte_done_o = 1'b0;
    nack_o      = 1'b0;
    sda_oe_o    = 1'b0;

    if (state_q != IDLE && !stretch) begin
      qcnt_d = qtick ? 8'd0 : qcnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        qcnt_d  = 8'd0;
        phase_d = 2'd0;
        if (go_i && !empty_i) begin
          state_d = START;
        end
      end

      START: begin
        sda_oe_o = (phase_q == 2'd1);
        if (qtick) begin
          if (phase_q == 2'd1) begin
            phase_d  = 2'd0;
            bitcnt_d = 3'd0;
            if (!empty_i) begin
              rd_o    = 1'b1;
              shreg_d = rdata_i;
              state_d = DATA;
            end else begin
              // FIFO drained under us: close the bus rather than underrun.
              state_d = STOP;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end

      DATA: begin
        sda_oe_o = ~shreg_q[7];
        if (qtick) begin
          phase_d = phase_q + 2'd1;
          // Shift only at the Q3->Q0 boundary so SDA moves while SCL is low.
          if (phase_q == 2'd3) begin
            if (bitcnt_q == 3'd7) begin
              state_d = ACK;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shreg_d  = {shreg_q[6:0], 1'b0};
            end
          end
        end
      end

      ACK: begin
        if (qtick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) begin
            ack_d = sda_i;
          end
          if (phase_q == 2'd3) begin
            if (!ack_q) begin
              byte_done_o = 1'b1;
              if (go_i && !empty_i) begin
                rd_o     = 1'b1;
                shreg_d  = rdata_i;
                bitcnt_d = 3'd0;
                state_d  = DATA;
              end else begin
                state_d = STOP;
              end
            end else begin
              nack_o  = 1'b1;
              state_d = STOP;
            end
          end
        end
      end

      STOP: begin
        sda_oe_o = (phase_q != 2'd2);
        if (qtick) begin
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        qcnt_d  = 8'd0;
        phase_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      qcnt_q   <= 8'd0;
      phase_q  <= 2'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ack_q    <= ack_d;
    end
  end

endmodule

// File: tb/tb_msft_dvip_i2c_tx_engine.sv
`timescale 1ns/1ps

module tb_msft_dvip_i2c_tx_engine;

  localparam int C = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       go_i = 1'b0;
  logic       empty_i;
  logic [7:0] rdata_i;
  logic       rd_o;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe_o;
  logic       sda_oe_o;
  logic       busy_o;
  logic       byte_done_o;
  logic       nack_o;

  msft_dvip_i2c_tx_engine #(.CLK_DIV(C)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .go_i(go_i), .empty_i(empty_i),
    .rdata_i(rdata_i), .rd_o(rd_o), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o), .busy_o(busy_o),
    .byte_done_o(byte_done_o), .nack_o(nack_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: written only by the stimulus block, popped only by the pop block.
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty_i = (rd_ptr == wr_ptr);
  assign rdata_i = fifo_mem[rd_ptr % 64];

  // Open-drain bus with a target that may pull SDA and a bench-forced SCL low.
  logic slave_pull = 1'b0;
  logic force_scl  = 1'b0;
  assign scl_i = ~(scl_oe_o | force_scl);
  assign sda_i = ~(sda_oe_o | slave_pull);

  int checks = 0;
  int errors = 0;

  // Event counters (only incremented here, read as deltas by the stimulus).
  int rd_cnt = 0, bd_cnt = 0, nack_cnt = 0, busy_cnt = 0, underrun = 0;
  logic pop_pend = 1'b0;

  always @(negedge clk_i) begin
    pop_pend = rd_o;
    if (rd_o) begin
      rd_cnt++;
      if (empty_i) underrun++;
    end
    if (byte_done_o) bd_cnt++;
    if (nack_o) nack_cnt++;
    if (busy_o) busy_cnt++;
  end

  always @(posedge clk_i) begin
    if (pop_pend && rstn_i) begin
      #1;
      rd_ptr = rd_ptr + 1;
    end
  end

  // Target model: decodes START/STOP and bits from the pad levels, ACKs per plan.
  logic       ack_plan [256];   // 1 = ACK the n-th received byte
  logic [7:0] rx_mem   [256];
  int         rx_cnt = 0, starts = 0, stops = 0;
  int         bitn = 0;
  logic [7:0] rx_sh = 8'd0;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      bitn = 0;
      slave_pull = 1'b0;
    end else if (p_scl && scl_i && p_sda && !sda_i) begin
      starts++;
      bitn = 0;
    end else if (p_scl && scl_i && !p_sda && sda_i) begin
      stops++;
      bitn = 0;
    end else if (!p_scl && scl_i) begin
      if (bitn < 8) rx_sh = {rx_sh[6:0], sda_i};
      bitn++;
      if (bitn == 8) begin
        rx_mem[rx_cnt % 256] = rx_sh;
        rx_cnt++;
      end
      if (bitn == 9) bitn = 0;
    end else if (p_scl && !scl_i) begin
      slave_pull = (bitn == 8) && ack_plan[(rx_cnt - 1) % 256];
    end
    p_scl = scl_i;
    p_sda = sda_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [7:0] tx_b [8];
  logic       tx_a [8];

  // Load n bytes, run a transfer, and compare against the transaction model:
  // bytes go out until the first NACK or FIFO end (or go drop), each byte
  // costs 36 quarters, START 2 quarters, STOP 3 quarters.
  task automatic run_xfer(input string tag, input int n, input int drop_at, input int exp_k_override);
    int k, acked, nk, t, b_rd, b_bd, b_nk, b_busy, b_st, b_sp, b_rx, b_un;
    k = 0; acked = 0; nk = 0;
    for (int i = 0; i < n; i++) begin
      k++;
      if (tx_a[i]) acked++;
      else begin nk = 1; break; end
    end
    if (exp_k_override > 0) begin
      k = exp_k_override; acked = k; nk = 0;
    end
    b_rd = rd_cnt; b_bd = bd_cnt; b_nk = nack_cnt; b_busy = busy_cnt;
    b_st = starts; b_sp = stops; b_rx = rx_cnt; b_un = underrun;
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 64] = tx_b[i];
      ack_plan[(b_rx + i) % 256] = tx_a[i];
      wr_ptr = wr_ptr + 1;
    end
    @(negedge clk_i);
    go_i = 1'b1;
    t = 0;
    while (!busy_o && t < 100) begin @(negedge clk_i); t++; end
    check({tag, "_busy_rise"}, busy_o, 1);
    t = 0;
    while (busy_o && t < 20000) begin
      @(negedge clk_i); t++;
      if (drop_at > 0 && t == drop_at) go_i = 1'b0;
    end
    go_i = 1'b0;
    check({tag, "_busy_fall"}, busy_o, 0);
    repeat (3) @(negedge clk_i);
    check({tag, "_cycles"}, busy_cnt - b_busy, 2*C + k*36*C + 3*C);
    check({tag, "_rd_pulses"}, rd_cnt - b_rd, k);
    check({tag, "_byte_done"}, bd_cnt - b_bd, acked);
    check({tag, "_nack"}, nack_cnt - b_nk, nk);
    check({tag, "_starts"}, starts - b_st, 1);
    check({tag, "_stops"}, stops - b_sp, 1);
    check({tag, "_fifo_left"}, wr_ptr - rd_ptr, n - k);
    check({tag, "_underrun"}, underrun - b_un, 0);
    check({tag, "_rx_count"}, rx_cnt - b_rx, k);
    for (int i = 0; i < k; i++)
      check($sformatf("%s_byte%0d", tag, i), rx_mem[(b_rx + i) % 256], tx_b[i]);
    check({tag, "_scl_idle"}, scl_oe_o, 0);
    check({tag, "_sda_idle"}, sda_oe_o, 0);
    wr_ptr = rd_ptr;  // drop leftovers
  endtask

  initial begin
    int b_rd, b_busy, b_sp, n, t, exp_len;

    // Reset state
    #2;
    check("rst_rd", rd_o, 0);
    check("rst_scl", scl_oe_o, 0);
    check("rst_sda", sda_oe_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_bd", byte_done_o, 0);
    check("rst_nack", nack_o, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // go with empty FIFO for 500 cycles
    b_rd = rd_cnt; b_busy = busy_cnt;
    go_i = 1'b1;
    repeat (500) @(negedge clk_i);
    go_i = 1'b0;
    check("empty_busy", busy_cnt - b_busy, 0);
    check("empty_rd", rd_cnt - b_rd, 0);
    check("empty_scl", scl_oe_o, 0);
    check("empty_sda", sda_oe_o, 0);

    // Two ACKed bytes
    tx_b[0] = 8'hA0; tx_a[0] = 1'b1;
    tx_b[1] = 8'h5A; tx_a[1] = 1'b1;
    run_xfer("ack2", 2, 0, 0);

    // NACK on first byte, second stays queued
    tx_b[0] = 8'h42; tx_a[0] = 1'b0;
    tx_b[1] = 8'h11; tx_a[1] = 1'b1;
    run_xfer("nack1", 2, 0, 0);

    // Randomized transfers
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        tx_b[i] = 8'($urandom);
        tx_a[i] = ($urandom_range(0, 3) != 0);
      end
      run_xfer($sformatf("rnd%0d", r), n, 0, 0);
    end

    // go dropped during byte 1 of 3
    tx_b[0] = 8'h3C; tx_a[0] = 1'b1;
    tx_b[1] = 8'hC3; tx_a[1] = 1'b1;
    tx_b[2] = 8'h99; tx_a[2] = 1'b1;
    run_xfer("godrop", 3, 60, 1);

    // SCL held low by the target for 40 cycles in DATA Q2
    fifo_mem[wr_ptr % 64] = 8'h81;
    ack_plan[rx_cnt % 256] = 1'b1;
    wr_ptr = wr_ptr + 1;
    b_busy = busy_cnt;
    @(negedge clk_i);
    go_i = 1'b1;
    t = 0;
    while (!scl_oe_o && t < 200) begin @(negedge clk_i); t++; end
    t = 0;
    while (scl_oe_o && t < 200) begin @(negedge clk_i); t++; end
    check("stretch_q2_reached", scl_oe_o, 0);
    force_scl = 1'b1;
    repeat (40) @(negedge clk_i);
    force_scl = 1'b0;
    go_i = 1'b0;
    t = 0;
    while (busy_o && t < 2000) begin @(negedge clk_i); t++; end
    check("stretch_done", busy_o, 0);
`ifdef I2C_TX_CLK_STRETCH_EN
    exp_len = 2*C + 36*C + 3*C + 40;
`else
    exp_len = 2*C + 36*C + 3*C;
`endif
    repeat (2) @(negedge clk_i);
    check("stretch_cycles", busy_cnt - b_busy, exp_len);
    wr_ptr = rd_ptr;

    // Reset during bit 3 of 0xFF
    fifo_mem[wr_ptr % 64] = 8'hFF;
    ack_plan[rx_cnt % 256] = 1'b1;
    wr_ptr = wr_ptr + 1;
    b_rd = rd_cnt; b_sp = stops;
    @(negedge clk_i);
    go_i = 1'b1;
    t = 0;
    while (!busy_o && t < 100) begin @(negedge clk_i); t++; end
    check("rstmid_busy", busy_o, 1);
    repeat (2*C + 3*4*C + 2) @(negedge clk_i);
    check("rstmid_scl_before", scl_oe_o, 1);
    #1 rstn_i = 1'b0;
    #1;
    check("rstmid_scl", scl_oe_o, 0);
    check("rstmid_sda", sda_oe_o, 0);
    check("rstmid_busy0", busy_o, 0);
    check("rstmid_rd", rd_o, 0);
    check("rstmid_bd", byte_done_o, 0);
    check("rstmid_nack", nack_o, 0);
    go_i = 1'b0;
    repeat (20) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("rstmid_busy_after", busy_o, 0);
    check("rstmid_pops", rd_cnt - b_rd, 1);
    check("rstmid_no_stop", stops - b_sp, 0);
    check("rstmid_fifo_empty", empty_i, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
